// File: rtl/nor_bus_ctrl.sv
// Parallel NOR flash bus master: single-word read/write requests in, cycle-counted
// async CE#/OE#/WE# strobes out, with a bounded RY/BY# wait after writes.
module nor_bus_ctrl #(
    parameter int ADDR_W       = 26,
    parameter int DATA_W       = 16,
    parameter int T_SETUP      = 2,
    parameter int T_ACCESS     = 8,
    parameter int T_WE         = 4,
    parameter int T_HOLD       = 2,
    parameter int BUSY_BLANK   = 4,
    parameter int BUSY_TIMEOUT = 4096
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_timeout,
    output logic [ADDR_W-1:0] nor_addr,
    output logic [DATA_W-1:0] nor_dq_out,
    output logic              nor_dq_oe,
    input  logic [DATA_W-1:0] nor_dq_in,
    output logic              nor_ce_n,
    output logic              nor_oe_n,
    output logic              nor_we_n,
    output logic              nor_byte_n,
    input  logic              nor_ry_by
);

    // state  | meaning
    // IDLE   | waiting for a request; ready only while the device reports ready
    // SETUP  | CE# low, address (and write data) settling before the strobe
    // READ   | OE# low; DQ captured on the last cycle
    // WRITE  | WE# low
    // HOLD   | CE# still low, strobes released, bus unchanged
    // BLANK  | after a write, RY/BY# ignored while the device asserts busy
    // BUSY   | waiting for RY/BY# high, bounded by the timeout counter
    // RESP   | one-cycle completion pulse
    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_READ, S_WRITE, S_HOLD, S_BLANK, S_BUSY, S_RESP
    } state_t;

    localparam int M1 = (T_SETUP > T_ACCESS) ? T_SETUP : T_ACCESS;
    localparam int M2 = (M1 > T_WE) ? M1 : T_WE;
    localparam int M3 = (M2 > T_HOLD) ? M2 : T_HOLD;
    localparam int M4 = (M3 > BUSY_BLANK) ? M3 : BUSY_BLANK;
    localparam int M5 = (M4 > BUSY_TIMEOUT) ? M4 : BUSY_TIMEOUT;
    localparam int CNT_W = $clog2(M5 + 1);

    localparam logic [CNT_W-1:0] LD_SETUP   = CNT_W'(T_SETUP - 1);
    localparam logic [CNT_W-1:0] LD_ACCESS  = CNT_W'(T_ACCESS - 1);
    localparam logic [CNT_W-1:0] LD_WE      = CNT_W'(T_WE - 1);
    localparam logic [CNT_W-1:0] LD_HOLD    = CNT_W'(T_HOLD - 1);
    localparam logic [CNT_W-1:0] LD_BLANK   = CNT_W'(BUSY_BLANK - 1);
    localparam logic [CNT_W-1:0] LD_TIMEOUT = CNT_W'(BUSY_TIMEOUT - 1);

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic               is_write, is_write_nxt;
    logic               tmo, tmo_nxt;
    logic               ry_s1, ry_s2;
    logic               req_ready_nxt, rsp_valid_nxt, rsp_timeout_nxt;
    logic [DATA_W-1:0]  rsp_rdata_nxt, dq_out_nxt;
    logic [ADDR_W-1:0]  addr_nxt;
    logic               dq_oe_nxt, ce_n_nxt, oe_n_nxt, we_n_nxt;
    logic               cnt_done;

    assign cnt_done = (cnt == '0);

    always_comb begin
        state_nxt       = state;
        cnt_nxt         = cnt;
        is_write_nxt    = is_write;
        tmo_nxt         = tmo;
        req_ready_nxt   = 1'b0;
        rsp_valid_nxt   = 1'b0;
        rsp_timeout_nxt = 1'b0;
        rsp_rdata_nxt   = rsp_rdata;
        addr_nxt        = nor_addr;
        dq_out_nxt      = nor_dq_out;
        dq_oe_nxt       = nor_dq_oe;
        ce_n_nxt        = nor_ce_n;
        oe_n_nxt        = nor_oe_n;
        we_n_nxt        = nor_we_n;
        if (!cnt_done) cnt_nxt = cnt - CNT_W'(1);

        case (state)
            S_IDLE: begin
                req_ready_nxt = ry_s2;
                if (req_valid && req_ready) begin
                    req_ready_nxt = 1'b0;
                    state_nxt     = S_SETUP;
                    cnt_nxt       = LD_SETUP;
                    is_write_nxt  = req_write;
                    tmo_nxt       = 1'b0;
                    addr_nxt      = req_addr;
                    ce_n_nxt      = 1'b0;
                    dq_oe_nxt     = req_write;
                    if (req_write) dq_out_nxt = req_wdata;
                end
            end
            S_SETUP: begin
                if (cnt_done) begin
                    if (is_write) begin
                        state_nxt = S_WRITE;
                        cnt_nxt   = LD_WE;
                        we_n_nxt  = 1'b0;
                    end else begin
                        state_nxt = S_READ;
                        cnt_nxt   = LD_ACCESS;
                        oe_n_nxt  = 1'b0;
                    end
                end
            end
            S_READ: begin
                if (cnt_done) begin
                    state_nxt     = S_HOLD;
                    cnt_nxt       = LD_HOLD;
                    oe_n_nxt      = 1'b1;
                    rsp_rdata_nxt = nor_dq_in;
                end
            end
            S_WRITE: begin
                if (cnt_done) begin
                    state_nxt = S_HOLD;
                    cnt_nxt   = LD_HOLD;
                    we_n_nxt  = 1'b1;
                end
            end
            S_HOLD: begin
                if (cnt_done) begin
                    ce_n_nxt  = 1'b1;
                    dq_oe_nxt = 1'b0;
                    if (is_write) begin
                        state_nxt = S_BLANK;
                        cnt_nxt   = LD_BLANK;
                    end else begin
                        state_nxt = S_RESP;
                    end
                end
            end
            S_BLANK: begin
                if (cnt_done) begin
                    state_nxt = S_BUSY;
                    cnt_nxt   = LD_TIMEOUT;
                end
            end
            S_BUSY: begin
                if (ry_s2) begin
                    state_nxt = S_RESP;
                end else if (cnt_done) begin
                    state_nxt = S_RESP;
                    tmo_nxt   = 1'b1;
                end
            end
            S_RESP: begin
                rsp_valid_nxt   = 1'b1;
                rsp_timeout_nxt = tmo;
                req_ready_nxt   = ry_s2;
                state_nxt       = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state       <= S_IDLE;
            cnt         <= '0;
            is_write    <= 1'b0;
            tmo         <= 1'b0;
            ry_s1       <= 1'b1;
            ry_s2       <= 1'b1;
            req_ready   <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_timeout <= 1'b0;
            nor_addr    <= '0;
            nor_dq_out  <= '0;
            nor_dq_oe   <= 1'b0;
            nor_ce_n    <= 1'b1;
            nor_oe_n    <= 1'b1;
            nor_we_n    <= 1'b1;
            nor_byte_n  <= 1'b1;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            is_write    <= is_write_nxt;
            tmo         <= tmo_nxt;
            ry_s1       <= nor_ry_by;
            ry_s2       <= ry_s1;
            req_ready   <= req_ready_nxt;
            rsp_valid   <= rsp_valid_nxt;
            rsp_rdata   <= rsp_rdata_nxt;
            rsp_timeout <= rsp_timeout_nxt;
            nor_addr    <= addr_nxt;
            nor_dq_out  <= dq_out_nxt;
            nor_dq_oe   <= dq_oe_nxt;
            nor_ce_n    <= ce_n_nxt;
            nor_oe_n    <= oe_n_nxt;
            nor_we_n    <= we_n_nxt;
            nor_byte_n  <= 1'b1;
        end
    end

endmodule
